// File: rtl/csr_issue_pkg.sv
// Shared widths and bundle layouts for the CSR issue buffer.
// Optional registered outputs: define CSR_ISSUE_REGOUT_EN.
package csr_issue_pkg;

   localparam int RB              = 1;
   localparam int PW              = 5 + RB;              // physical register index width
   localparam int CSR_DISPAT_DW   = 4 + 2*PW + 5 + 12;
   localparam int CSR_EXEPARAM_DW = 3 + PW + 64 + 12;

   typedef struct packed {
      logic          rw;
      logic          rs;
      logic          rc;
      logic          is_imm;
      logic [PW-1:0] rd0;
      logic [PW-1:0] rs1;
      logic [4:0]    uimm;
      logic [11:0]   addr;
   } dispat_info_t;

   typedef struct packed {
      logic          rw;
      logic          rs;
      logic          rc;
      logic [PW-1:0] rd0;
      logic [63:0]   op;
      logic [11:0]   addr;
   } exeparam_t;

   // RS/RC with a zero operand must not write the CSR, so the zero cases are exact.
   function automatic logic [63:0] sel_op(input dispat_info_t i, input logic [63:0] rdata);
      if (i.is_imm)
         return {59'b0, i.uimm};
      else if (i.rs1 == '0)
         return 64'b0;
      else
         return rdata;
   endfunction

endpackage

// File: rtl/csr_issue_fifo.sv
// Circular DP x IW buffer with (log2 DP)+1-bit pointers; flush clears it like reset.
module csr_issue_fifo
   import csr_issue_pkg::*;
#(
   parameter int DP = 4,
   parameter int IW = CSR_DISPAT_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  logic [IW-1:0] wdata,
   output logic [IW-1:0] head,
   output logic          empty,
   output logic          full
);

   localparam int AW = $clog2(DP);

   logic [AW:0]   wr_ptr, rd_ptr;
   logic [DP-1:0] ent_vld;
   logic [IW-1:0] mem [DP];
   logic          do_push, do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign do_push = push & ~full & ~flush & rst_n;
   assign do_pop  = pop & ~empty;

   // Masking by the entry valid bit keeps the head at zero while empty.
   assign head = ent_vld[rd_ptr[AW-1:0]] ? mem[rd_ptr[AW-1:0]] : '0;

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         ent_vld <= '0;
      end else begin
         if (do_pop) begin
            ent_vld[rd_ptr[AW-1:0]] <= 1'b0;
            rd_ptr                  <= rd_ptr + 1'b1;
         end
         if (do_push) begin
            ent_vld[wr_ptr[AW-1:0]] <= 1'b1;
            wr_ptr                  <= wr_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/csr_issue.sv
// In-order CSR issue buffer: holds dispatched CSR ops and fires the head on commit permission.
// Define CSR_ISSUE_REGOUT_EN to register csr_exeparam_vaild/csr_exeparam (+1 cycle latency).
module csr_issue
   import csr_issue_pkg::*;
#(
   parameter int DP = 4,
   parameter int DW = CSR_EXEPARAM_DW,
   parameter int IW = CSR_DISPAT_DW
) (
   input  logic          CLK,
   input  logic          RSTn,
   input  logic          flush,
   input  logic          csr_dispat_vaild,
   output logic          csr_dispat_ready,
   input  logic [IW-1:0] csr_dispat_info,
   input  logic          csr_issue_permit,
   output logic [PW-1:0] rs1_phy,
   input  logic          rs1_ready,
   input  logic [63:0]   rs1_data,
   output logic          csr_exeparam_vaild,
   output logic [DW-1:0] csr_exeparam
);

   logic          empty, full, fire;
   logic [IW-1:0] head_raw;
   dispat_info_t  hd;
   exeparam_t     nxt;

   csr_issue_fifo #(.DP(DP), .IW(IW)) u_fifo (
      .clk   (CLK),
      .rst_n (RSTn),
      .flush (flush),
      .push  (csr_dispat_vaild),
      .pop   (fire),
      .wdata (csr_dispat_info),
      .head  (head_raw),
      .empty (empty),
      .full  (full)
   );

   assign hd               = dispat_info_t'(head_raw);
   assign csr_dispat_ready = ~full;
   assign rs1_phy          = hd.rs1;

   // Flush and reset both squash a fire in their own cycle.
   assign fire = ~empty & csr_issue_permit & ~flush & RSTn
               & (hd.is_imm | rs1_ready | (hd.rs1 == '0));

   always_comb begin
      nxt = '0;
      if (fire) begin
         nxt.rw   = hd.rw;
         nxt.rs   = hd.rs;
         nxt.rc   = hd.rc;
         nxt.rd0  = hd.rd0;
         nxt.op   = sel_op(hd, rs1_data);
         nxt.addr = hd.addr;
      end
   end

`ifdef CSR_ISSUE_REGOUT_EN
   logic      vld_q;
   exeparam_t param_q;

   always_ff @(posedge CLK) begin
      if (!RSTn || flush) begin
         vld_q   <= 1'b0;
         param_q <= '0;
      end else begin
         vld_q   <= fire;
         param_q <= nxt;
      end
   end

   assign csr_exeparam_vaild = vld_q;
   assign csr_exeparam       = param_q;
`else
   assign csr_exeparam_vaild = fire;
   assign csr_exeparam       = nxt;
`endif

endmodule

// File: tb/tb_csr_issue.sv
// Directed bench for csr_issue; expected values are hand-built from the bundle layouts.
module tb_csr_issue;
   import csr_issue_pkg::*;

`ifdef CSR_ISSUE_REGOUT_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   logic                       CLK = 1'b0;
   logic                       RSTn;
   logic                       flush;
   logic                       csr_dispat_vaild;
   logic                       csr_dispat_ready;
   logic [CSR_DISPAT_DW-1:0]   csr_dispat_info;
   logic                       csr_issue_permit;
   logic [PW-1:0]              rs1_phy;
   logic                       rs1_ready;
   logic [63:0]                rs1_data;
   logic                       csr_exeparam_vaild;
   logic [CSR_EXEPARAM_DW-1:0] csr_exeparam;

   int n_tests = 0;
   int n_fail  = 0;

   csr_issue #(.DP(4)) dut (
      .CLK                (CLK),
      .RSTn               (RSTn),
      .flush              (flush),
      .csr_dispat_vaild   (csr_dispat_vaild),
      .csr_dispat_ready   (csr_dispat_ready),
      .csr_dispat_info    (csr_dispat_info),
      .csr_issue_permit   (csr_issue_permit),
      .rs1_phy            (rs1_phy),
      .rs1_ready          (rs1_ready),
      .rs1_data           (rs1_data),
      .csr_exeparam_vaild (csr_exeparam_vaild),
      .csr_exeparam       (csr_exeparam)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [CSR_DISPAT_DW-1:0] mk_info(
      input logic rw, input logic rs, input logic rc, input logic imm,
      input logic [PW-1:0] rd0, input logic [PW-1:0] rs1,
      input logic [4:0] uimm, input logic [11:0] addr);
      return {rw, rs, rc, imm, rd0, rs1, uimm, addr};
   endfunction

   function automatic logic [CSR_EXEPARAM_DW-1:0] mk_param(
      input logic rw, input logic rs, input logic rc,
      input logic [PW-1:0] rd0, input logic [63:0] op, input logic [11:0] addr);
      return {rw, rs, rc, rd0, op, addr};
   endfunction

   // Checks the issue strobe belonging to the current cycle's inputs, then advances one cycle.
   task automatic cycle_chk(input string tag, input logic vld, input logic [CSR_EXEPARAM_DW-1:0] prm);
      #1;
      if (LAT == 0) begin
         chk({tag, ".vld"}, csr_exeparam_vaild, vld);
         chk({tag, ".prm"}, csr_exeparam, prm);
      end
      tick();
      if (LAT == 1) begin
         chk({tag, ".vld"}, csr_exeparam_vaild, vld);
         chk({tag, ".prm"}, csr_exeparam, prm);
      end
   endtask

   initial begin
      RSTn = 1'b0; flush = 1'b0; csr_dispat_vaild = 1'b0; csr_dispat_info = '0;
      csr_issue_permit = 1'b0; rs1_ready = 1'b0; rs1_data = '0;
      tick(); tick();
      chk("rst.vld", csr_exeparam_vaild, 1'b0);
      chk("rst.prm", csr_exeparam, '0);
      chk("rst.rdy", csr_dispat_ready, 1'b1);
      chk("rst.rs1", rs1_phy, '0);
      RSTn = 1'b1;
      tick();

      // 1: CSRRWI 0x305, uimm 5, rd0 7
      csr_issue_permit = 1'b1;
      csr_dispat_vaild = 1'b1;
      csr_dispat_info  = mk_info(1, 0, 0, 1, 7, 0, 5, 12'h305);
      cycle_chk("t1.disp", 0, '0);
      csr_dispat_vaild = 1'b0;
      cycle_chk("t1.iss", 1, mk_param(1, 0, 0, 7, 64'h5, 12'h305));
      cycle_chk("t1.idle", 0, '0);
      chk("t1.rdy", csr_dispat_ready, 1'b1);
      chk("t1.rs1", rs1_phy, '0);

      // 2: CSRRS rs1=9 waits on rs1_ready
      csr_dispat_vaild = 1'b1;
      csr_dispat_info  = mk_info(0, 1, 0, 0, 3, 9, 0, 12'h300);
      cycle_chk("t2.disp", 0, '0);
      csr_dispat_vaild = 1'b0;
      chk("t2.rs1", rs1_phy, 6'd9);
      for (int i = 0; i < 3; i++) cycle_chk("t2.wait", 0, '0);
      rs1_ready = 1'b1; rs1_data = 64'hA5;
      cycle_chk("t2.iss", 1, mk_param(0, 1, 0, 3, 64'hA5, 12'h300));
      rs1_ready = 1'b0; rs1_data = '0;
      cycle_chk("t2.idle", 0, '0);

      // 3: fill to DP with permit low, 5th push dropped, then drain in order across the wrap
      csr_issue_permit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         csr_dispat_vaild = 1'b1;
         csr_dispat_info  = mk_info(1, 0, 0, 1, PW'(i), PW'(20 + i), 5'(i + 1), 12'(12'h340 + i));
         chk("t3.rdy", csr_dispat_ready, 1'b1);
         cycle_chk("t3.fill", 0, '0);
      end
      csr_dispat_info = mk_info(1, 0, 0, 1, 6'd5, 6'd30, 5'd9, 12'h3ff);
      chk("t3.full", csr_dispat_ready, 1'b0);
      cycle_chk("t3.drop", 0, '0);
      csr_dispat_vaild = 1'b0;
      chk("t3.head", rs1_phy, 6'd20);
      csr_issue_permit = 1'b1;
      for (int i = 0; i < 4; i++)
         cycle_chk("t3.drain", 1, mk_param(1, 0, 0, PW'(i), 64'(i + 1), 12'(12'h340 + i)));
      cycle_chk("t3.empty", 0, '0);

      // 4: push and fire together at occupancy 2
      csr_issue_permit = 1'b0;
      csr_dispat_vaild = 1'b1;
      csr_dispat_info  = mk_info(1, 0, 0, 1, 1, 0, 5'd11, 12'h350);
      cycle_chk("t4.pa", 0, '0);
      csr_dispat_info  = mk_info(0, 1, 0, 1, 2, 0, 5'd12, 12'h351);
      cycle_chk("t4.pb", 0, '0);
      csr_issue_permit = 1'b1;
      csr_dispat_info  = mk_info(0, 0, 1, 1, 3, 0, 5'd13, 12'h352);
      cycle_chk("t4.a", 1, mk_param(1, 0, 0, 1, 64'd11, 12'h350));
      csr_dispat_vaild = 1'b0;
      cycle_chk("t4.b", 1, mk_param(0, 1, 0, 2, 64'd12, 12'h351));
      cycle_chk("t4.c", 1, mk_param(0, 0, 1, 3, 64'd13, 12'h352));
      cycle_chk("t4.empty", 0, '0);

      // 5: flush with 3 entries, permit high, concurrent push
      csr_issue_permit = 1'b0;
      csr_dispat_vaild = 1'b1;
      for (int i = 0; i < 3; i++) begin
         csr_dispat_info = mk_info(1, 0, 0, 1, PW'(i), PW'(1 + i), 5'(i), 12'h360);
         cycle_chk("t5.fill", 0, '0);
      end
      csr_issue_permit = 1'b1;
      flush = 1'b1;
      csr_dispat_info = mk_info(1, 0, 0, 1, 6'd9, 6'd9, 5'd9, 12'h369);
      cycle_chk("t5.flush", 0, '0);
      flush = 1'b0;
      csr_dispat_vaild = 1'b0;
      chk("t5.rdy", csr_dispat_ready, 1'b1);
      chk("t5.rs1", rs1_phy, '0);
      cycle_chk("t5.after", 0, '0);

      // 6: CSRRC rs1=0 issues op=0 regardless of regfile data
      rs1_data = 64'hFFFF_FFFF_FFFF_FFFF;
      csr_dispat_vaild = 1'b1;
      csr_dispat_info  = mk_info(0, 0, 1, 0, 4, 0, 5'd0, 12'h344);
      cycle_chk("t6.disp", 0, '0);
      csr_dispat_vaild = 1'b0;
      cycle_chk("t6.iss", 1, mk_param(0, 0, 1, 4, 64'h0, 12'h344));

      // reset mid-stream with entries queued and a push pending
      csr_issue_permit = 1'b0;
      csr_dispat_vaild = 1'b1;
      csr_dispat_info  = mk_info(1, 0, 0, 1, 5, 7, 5'd3, 12'h370);
      tick();
      tick();
      RSTn = 1'b0;
      csr_issue_permit = 1'b1;
      tick();
      RSTn = 1'b1;
      csr_dispat_vaild = 1'b0;
      #1;
      chk("t6.rst.vld", csr_exeparam_vaild, 1'b0);
      chk("t6.rst.prm", csr_exeparam, '0);
      chk("t6.rst.rdy", csr_dispat_ready, 1'b1);
      chk("t6.rst.rs1", rs1_phy, '0);
      cycle_chk("t6.after", 0, '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
